// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the QSPI command sequencer.
// Holds the frame FSM state encoding, command byte field positions and the
// default status byte shown to the host while command and address are in flight.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_WDATA   = 3'd3,
    S_RDATA   = 3'd4,
    S_DISCARD = 3'd5
  } state_t;

  // Command byte layout: bit7 read/not-write, bit6 auto-increment, bits5:0 reserved zero
  localparam int         READ_BIT            = 7;
  localparam int         INC_BIT             = 6;
  localparam logic [5:0] RSVD_MASK           = 6'h3F;
  localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

  // A command is malformed when any reserved bit is set
  function automatic logic cmd_bad(input logic [7:0] cmd);
    return (cmd[5:0] & RSVD_MASK) != 6'h00;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the bad-frame tally.
// One increment per cycle when i_inc is high; holds at all-ones instead of
// wrapping, so a flood of bad frames never masks itself by rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Count up on request, stick at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frame-level QSPI slave controller: decodes command/address/data bytes and
// issues single-cycle register bank strobes, one cycle after the triggering byte.
// No backpressure: relies on a byte period of at least 4 clk cycles from the shifter.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT,
  parameter int         ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_active,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [7:0]       tx_data,
  output logic [7:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_count
);

  // Registered state
  state_t     r_state;
  logic       r_read;
  logic       r_inc;
  logic [7:0] r_tx;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_we;
  logic       r_re;
  logic       r_re_d;
  logic       r_frame_done;

  // Next-cycle values
  state_t     w_adv;
  state_t     w_state_nxt;
  logic       w_read_nxt;
  logic       w_inc_nxt;
  logic [7:0] w_tx_nxt;
  logic [7:0] w_addr_nxt;
  logic [7:0] w_wdata_nxt;
  logic       w_we_nxt;
  logic       w_re_nxt;
  logic       w_fd_nxt;
  logic       w_err_inc;

  // Decode the current byte and chip-select, producing next state and outputs.
  // w_adv is where the byte alone would take us; a chip-select drop then
  // overrides to IDLE and is classified by that post-byte state, so a byte
  // arriving together with the CS drop is still fully processed.
  always_comb begin
    w_adv       = r_state;
    w_state_nxt = r_state;
    w_read_nxt  = r_read;
    w_inc_nxt   = r_inc;
    w_tx_nxt    = r_tx;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_err_inc   = 1'b0;

    // Auto-increment after a write lands the cycle after the strobe, so the
    // strobe itself always carries the address the host sent.
    if (r_we && r_inc) begin
      w_addr_nxt = r_addr + 8'd1;
    end

    // Bank returns data one cycle after reg_re; present it on the next slot
    if (r_re_d) begin
      w_tx_nxt = reg_rdata;
    end

    case (r_state)
      S_IDLE: begin
        if (cs_active) begin
          w_adv    = S_CMD;
          w_tx_nxt = STATUS_BYTE;
        end
      end

      S_CMD: begin
        if (rx_valid) begin
          if (cmd_bad(rx_data)) begin
            w_adv     = S_DISCARD;
            w_err_inc = 1'b1;
          end else begin
            w_read_nxt = rx_data[READ_BIT];
            w_inc_nxt  = rx_data[INC_BIT];
            w_adv      = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          w_addr_nxt = rx_data;
          if (r_read) begin
            // Prefetch the first read so data is ready for the first dummy slot
            w_re_nxt = 1'b1;
            w_adv    = S_RDATA;
          end else begin
            w_adv = S_WDATA;
          end
        end
      end

      S_WDATA: begin
        if (rx_valid) begin
          w_wdata_nxt = rx_data;
          w_we_nxt    = 1'b1;
        end
      end

      S_RDATA: begin
        // Each dummy byte fetches the value for the following slot
        if (rx_valid) begin
          w_re_nxt = 1'b1;
          if (r_inc) begin
            w_addr_nxt = r_addr + 8'd1;
          end
        end
      end

      S_DISCARD: begin
        // Malformed frame: swallow bytes until chip-select drops
      end

      default: begin
        w_adv = S_IDLE;
      end
    endcase

    w_state_nxt = w_adv;

    // Frame end: clean after any data phase, short if no address was taken
    if ((r_state != S_IDLE) && !cs_active) begin
      w_state_nxt = S_IDLE;
      case (w_adv)
        S_WDATA, S_RDATA: w_fd_nxt  = 1'b1;
        S_CMD, S_ADDR:    w_err_inc = 1'b1;
        default:          ;
      endcase
    end
  end

  // State and output registers; reset clears everything including strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_read       <= 1'b0;
      r_inc        <= 1'b0;
      r_tx         <= 8'h00;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_re_d       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read       <= w_read_nxt;
      r_inc        <= w_inc_nxt;
      r_tx         <= w_tx_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_we         <= w_we_nxt;
      r_re         <= w_re_nxt;
      r_re_d       <= r_re;
      r_frame_done <= w_fd_nxt;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_err_inc),
    .o_count(err_count)
  );

  assign tx_data    = r_tx;
  assign reg_addr   = r_addr;
  assign reg_wdata  = r_wdata;
  assign reg_we     = r_we;
  assign reg_re     = r_re;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed vector table, hand-timed corner cases,
// and random frames checked against a frame-level model of the protocol.
// The register bank responder answers reads one cycle after reg_re.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset, cs_active, rx_valid;
  logic [7:0] rx_data, tx_data, reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_we, reg_re, frame_done;
  logic [7:0] err_count;

  spi_cmd_sequencer #(.STATUS_BYTE(8'hA5), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .frame_done(frame_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Register bank: unwritten locations read as 0xA0 + address
  logic [7:0] bank [256];
  logic       bank_wr [256] = '{default: 1'b0};
  always @(posedge clk) begin
    if (reg_we) begin
      bank[reg_addr]    <= reg_wdata;
      bank_wr[reg_addr] <= 1'b1;
    end
    if (reg_re) reg_rdata <= bank_wr[reg_addr] ? bank[reg_addr] : 8'hA0 + reg_addr;
    else        reg_rdata <= 8'h00;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Observed activity
  logic [15:0] w_log [$];
  logic [7:0]  r_log [$];
  logic [7:0]  tx_log [$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (reg_we) w_log.push_back({reg_addr, reg_wdata});
    if (reg_re) r_log.push_back(reg_addr);
    if (frame_done) fd_cnt++;
    if (reg_we || reg_re) chk("strobe_excl", {31'd0, reg_we & reg_re}, 32'd0);
  end

  // Frame-level reference model
  logic [7:0]  mdl_mem [256];
  logic [15:0] exp_w [$];
  logic [7:0]  exp_r [$];
  logic [7:0]  exp_tx [$];
  int          exp_fd;
  int          exp_err;
  logic [7:0]  fb [$];

  task automatic model_frame();
    int n = fb.size();
    logic [7:0] a;
    logic rd, inc;
    exp_w.delete(); exp_r.delete(); exp_tx.delete(); exp_fd = 0;
    for (int j = 0; j <= n; j++) exp_tx.push_back(8'hA5);
    if (n < 2 || fb[0][5:0] != 6'd0) begin
      if (exp_err < 255) exp_err++;
      return;
    end
    exp_fd = 1;
    a   = fb[1];
    rd  = fb[0][7];
    inc = fb[0][6];
    if (!rd) begin
      for (int j = 2; j < n; j++) begin
        exp_w.push_back({a, fb[j]});
        mdl_mem[a] = fb[j];
        if (inc) a++;
      end
    end else begin
      for (int j = 2; j <= n; j++) begin
        exp_r.push_back(a);
        exp_tx[j] = mdl_mem[a];
        if (inc) a++;
      end
    end
  endtask

  // Drive one byte (called at a negedge), 6-cycle byte period
  task automatic send_byte(input logic [7:0] b);
    tx_log.push_back(tx_data);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_frame();
    w_log.delete(); r_log.delete(); tx_log.delete(); fd_cnt = 0;
    cs_active = 1'b1;
    repeat (2) @(negedge clk);
    foreach (fb[i]) send_byte(fb[i]);
    tx_log.push_back(tx_data);
    cs_active = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "/n_wr"}, w_log.size(), exp_w.size());
    foreach (exp_w[i]) if (i < w_log.size()) chk({tag, "/wr"}, {16'd0, w_log[i]}, {16'd0, exp_w[i]});
    chk({tag, "/n_rd"}, r_log.size(), exp_r.size());
    foreach (exp_r[i]) if (i < r_log.size()) chk({tag, "/rd"}, {24'd0, r_log[i]}, {24'd0, exp_r[i]});
    chk({tag, "/n_tx"}, tx_log.size(), exp_tx.size());
    foreach (exp_tx[i]) if (i < tx_log.size()) chk({tag, "/tx"}, {24'd0, tx_log[i]}, {24'd0, exp_tx[i]});
    chk({tag, "/frame_done"}, fd_cnt, exp_fd);
    chk({tag, "/err"}, {24'd0, err_count}, exp_err);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "/tx"},    {24'd0, tx_data},   32'h00);
    chk({tag, "/addr"},  {24'd0, reg_addr},  32'h00);
    chk({tag, "/wdata"}, {24'd0, reg_wdata}, 32'h00);
    chk({tag, "/we"},    {31'd0, reg_we},    32'd0);
    chk({tag, "/re"},    {31'd0, reg_re},    32'd0);
    chk({tag, "/fd"},    {31'd0, frame_done}, 32'd0);
    chk({tag, "/err"},   {24'd0, err_count}, 32'h00);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [6];
    int         n_wr;
    int         n_rd;
    logic [7:0] last_addr;  // address of the last strobe
    logic [7:0] last_val;   // last write data, or final tx for reads
    int         fd;
    logic [7:0] err;        // err_count after the frame
    logic [7:0] end_addr;   // reg_addr after the frame
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5, '{8'h40, 8'h10, 8'h11, 8'h22, 8'h33, 8'h00}, 3, 0, 8'h12, 8'h33, 1, 8'h00, 8'h13};
    tbl[1] = '{4, '{8'hC0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 3, 8'h07, 8'hA7, 1, 8'h00, 8'h07};
    tbl[2] = '{4, '{8'h40, 8'hFF, 8'h5A, 8'h6B, 8'h00, 8'h00}, 2, 0, 8'h00, 8'h6B, 1, 8'h00, 8'h01};
    tbl[3] = '{4, '{8'h41, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00}, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h01};
    tbl[4] = '{1, '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h00, 8'h00, 0, 8'h02, 8'h01};
    tbl[5] = '{4, '{8'h80, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 3, 8'h30, 8'hD0, 1, 8'h02, 8'h30};
    tbl[6] = '{4, '{8'h00, 8'h20, 8'h77, 8'h88, 8'h00, 8'h00}, 2, 0, 8'h20, 8'h88, 1, 8'h02, 8'h20};
    tbl[7] = '{3, '{8'hC0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 2, 8'h21, 8'hC1, 1, 8'h02, 8'h21};

    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'hA0 + 8'(i);
    exp_err = 0;

    reset = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int t = 0; t < 8; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      fb.delete();
      for (int i = 0; i < tbl[t].n; i++) fb.push_back(tbl[t].b[i]);
      model_frame();
      do_frame();
      compare_frame(tag);
      chk({tag, "/tbl_n_wr"}, w_log.size(), tbl[t].n_wr);
      chk({tag, "/tbl_n_rd"}, r_log.size(), tbl[t].n_rd);
      if (tbl[t].n_wr > 0 && w_log.size() > 0) begin
        chk({tag, "/last_wa"}, {24'd0, w_log[w_log.size()-1][15:8]}, {24'd0, tbl[t].last_addr});
        chk({tag, "/last_wd"}, {24'd0, w_log[w_log.size()-1][7:0]},  {24'd0, tbl[t].last_val});
      end
      if (tbl[t].n_rd > 0 && r_log.size() > 0) begin
        chk({tag, "/last_ra"}, {24'd0, r_log[r_log.size()-1]},   {24'd0, tbl[t].last_addr});
        chk({tag, "/last_tx"}, {24'd0, tx_log[tx_log.size()-1]}, {24'd0, tbl[t].last_val});
      end
      chk({tag, "/tbl_fd"},   fd_cnt, tbl[t].fd);
      chk({tag, "/tbl_err"},  {24'd0, err_count}, {24'd0, tbl[t].err});
      chk({tag, "/end_addr"}, {24'd0, reg_addr},  {24'd0, tbl[t].end_addr});
    end

    // Read latency: strobe 1 cycle after the address byte, tx 3 cycles after
    fd_cnt = 0;
    cs_active = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h80);
    rx_data = 8'h42; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("lat/re_1cyc", {31'd0, reg_re}, 32'd1);
    chk("lat/re_addr", {24'd0, reg_addr}, 32'h42);
    @(negedge clk);
    chk("lat/re_pulse", {31'd0, reg_re}, 32'd0);
    chk("lat/tx_hold", {24'd0, tx_data}, 32'hA5);
    @(negedge clk);
    chk("lat/tx_3cyc", {24'd0, tx_data}, {24'd0, mdl_mem[8'h42]});
    repeat (3) @(negedge clk);
    cs_active = 1'b0;
    repeat (4) @(negedge clk);
    chk("lat/frame_done", fd_cnt, 1);

    // Last data byte arrives in the same cycle CS drops
    fd_cnt = 0; w_log.delete();
    cs_active = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h40);
    send_byte(8'h60);
    rx_data = 8'h99; rx_valid = 1'b1; cs_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("csdrop/we",    {31'd0, reg_we}, 32'd1);
    chk("csdrop/addr",  {24'd0, reg_addr}, 32'h60);
    chk("csdrop/wdata", {24'd0, reg_wdata}, 32'h99);
    chk("csdrop/fd",    {31'd0, frame_done}, 32'd1);
    repeat (4) @(negedge clk);
    chk("csdrop/n_wr", w_log.size(), 1);
    chk("csdrop/n_fd", fd_cnt, 1);
    chk("csdrop/err", {24'd0, err_count}, exp_err);
    chk("csdrop/post_inc", {24'd0, reg_addr}, 32'h61);
    mdl_mem[8'h60] = 8'h99;

    // Reset between data bytes, then a byte with CS still high
    cs_active = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h40);
    send_byte(8'h50);
    send_byte(8'h01);
    mdl_mem[8'h50] = 8'h01;
    reset = 1'b1;
    @(negedge clk);
    reset_checks("rst_mid");
    exp_err = 0;
    reset = 1'b0;
    w_log.delete(); r_log.delete();
    repeat (2) @(negedge clk);
    send_byte(8'h80);
    chk("rst_mid/no_strobe", w_log.size() + r_log.size(), 0);
    chk("rst_mid/no_err", {24'd0, err_count}, 32'h00);
    reset = 1'b1; cs_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Random frames against the model
    for (int f = 0; f < 40; f++) begin
      int n;
      logic [7:0] cmd;
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) cmd = {2'($urandom), 6'($urandom_range(1, 63))};
      else                           cmd = {2'($urandom), 6'd0};
      fb.delete();
      for (int i = 0; i < n; i++) begin
        if (i == 0)      fb.push_back(cmd);
        else if (i == 1) fb.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom));
        else             fb.push_back(8'($urandom));
      end
      model_frame();
      do_frame();
      compare_frame($sformatf("rnd%0d", f));
    end

    // Saturation: 300 bad-command frames
    fb.delete();
    fb.push_back(8'h41);
    repeat (300) do_frame();
    chk("sat/err", {24'd0, err_count}, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
